// File: rtl/uncache_axi_bridge_if.sv
// -----------------------------------------------------------------------------
// uncache_axi_bridge_if
// AXI4 single-beat bus bundle between the uncache bridge and the interconnect.
//   master modport : bridge side (drives AR/AW/W channels, rready, bready)
//   slave  modport : interconnect side (drives ready/data/response signals)
// Read channels : araddr, arsize, arvalid, arready, rdata, rresp, rvalid, rready
// Write channels: awaddr, awsize, awvalid, awready, wdata, wstrb, wvalid,
//                 wready, bresp, bvalid, bready   (wlast is implied 1)
// -----------------------------------------------------------------------------
interface uncache_axi_bridge_if;
    logic [31:0] araddr;
    logic [2:0]  arsize;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic [2:0]  awsize;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output araddr, arsize, arvalid, rready,
        output awaddr, awsize, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid,
        input  awready, wready, bresp, bvalid
    );

    modport slave (
        input  araddr, arsize, arvalid, rready,
        input  awaddr, awsize, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid,
        output awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/uncache_axi_bridge.sv
// -----------------------------------------------------------------------------
// uncache_axi_bridge
// Converts held uncached read/write request levels from the uncache stage into
// single-beat AXI transactions, one outstanding at a time, and returns a
// one-cycle reload pulse on completion.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   rd_req, rd_addr   : read request level and physical address
//   wr_req, wr_wstrb,
//   wr_addr, wr_data  : write request level, strobes, address, data
//   reload            : one-cycle completion pulse
//   rd_data           : read data, valid in the reload cycle of a read
//   axi               : AXI bus (master modport)
// Every AXI output and reload comes straight from a flop.
// -----------------------------------------------------------------------------
module uncache_axi_bridge (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rd_req,
    input  logic [31:0]                rd_addr,
    input  logic                       wr_req,
    input  logic [3:0]                 wr_wstrb,
    input  logic [31:0]                wr_addr,
    input  logic [31:0]                wr_data,
    output logic                       reload,
    output logic [31:0]                rd_data,
    uncache_axi_bridge_if.master       axi
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AR   = 3'd1,
        ST_R    = 3'd2,
        ST_AW_W = 3'd3,
        ST_B    = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    state_t      state_r,   state_nxt_s;
    logic        reload_r,  reload_nxt_s;
    logic [31:0] rd_data_r, rd_data_nxt_s;
    logic [31:0] araddr_r,  araddr_nxt_s;
    logic        arvalid_r, arvalid_nxt_s;
    logic        rready_r,  rready_nxt_s;
    logic [31:0] awaddr_r,  awaddr_nxt_s;
    logic        awvalid_r, awvalid_nxt_s;
    logic [31:0] wdata_r,   wdata_nxt_s;
    logic [3:0]  wstrb_r,   wstrb_nxt_s;
    logic        wvalid_r,  wvalid_nxt_s;
    logic        bready_r,  bready_nxt_s;
    logic        aw_done_r, aw_done_nxt_s;
    logic        w_done_r,  w_done_nxt_s;

    logic        aw_hs_s;
    logic        w_hs_s;
    logic        unused_resp_s;

    assign aw_hs_s = awvalid_r & axi.awready;
    assign w_hs_s  = wvalid_r & axi.wready;

    // Responses are deliberately ignored: error responses complete like OKAY.
    assign unused_resp_s = ^{axi.rresp, axi.bresp};

    assign reload      = reload_r;
    assign rd_data     = rd_data_r;
    assign axi.araddr  = araddr_r;
    assign axi.arsize  = 3'b010;
    assign axi.arvalid = arvalid_r;
    assign axi.rready  = rready_r;
    assign axi.awaddr  = awaddr_r;
    assign axi.awsize  = 3'b010;
    assign axi.awvalid = awvalid_r;
    assign axi.wdata   = wdata_r;
    assign axi.wstrb   = wstrb_r;
    assign axi.wvalid  = wvalid_r;
    assign axi.bready  = bready_r;

    // Next-state and next-output computation for the transaction FSM.
    always_comb begin
        state_nxt_s   = state_r;
        reload_nxt_s  = 1'b0;
        rd_data_nxt_s = rd_data_r;
        araddr_nxt_s  = araddr_r;
        arvalid_nxt_s = arvalid_r;
        rready_nxt_s  = rready_r;
        awaddr_nxt_s  = awaddr_r;
        awvalid_nxt_s = awvalid_r;
        wdata_nxt_s   = wdata_r;
        wstrb_nxt_s   = wstrb_r;
        wvalid_nxt_s  = wvalid_r;
        bready_nxt_s  = bready_r;
        aw_done_nxt_s = aw_done_r;
        w_done_nxt_s  = w_done_r;

        case (state_r)
            ST_IDLE: begin
                // Write has priority when both request levels are high.
                if (wr_req) begin
                    awaddr_nxt_s  = wr_addr;
                    wdata_nxt_s   = wr_data;
                    wstrb_nxt_s   = wr_wstrb;
                    awvalid_nxt_s = 1'b1;
                    wvalid_nxt_s  = 1'b1;
                    aw_done_nxt_s = 1'b0;
                    w_done_nxt_s  = 1'b0;
                    state_nxt_s   = ST_AW_W;
                end else if (rd_req) begin
                    araddr_nxt_s  = rd_addr;
                    arvalid_nxt_s = 1'b1;
                    state_nxt_s   = ST_AR;
                end else begin
                    state_nxt_s   = ST_IDLE;
                end
            end
            ST_AR: begin
                if (arvalid_r && axi.arready) begin
                    arvalid_nxt_s = 1'b0;
                    rready_nxt_s  = 1'b1;
                    state_nxt_s   = ST_R;
                end else begin
                    state_nxt_s   = ST_AR;
                end
            end
            ST_R: begin
                if (rready_r && axi.rvalid) begin
                    rd_data_nxt_s = axi.rdata;
                    rready_nxt_s  = 1'b0;
                    reload_nxt_s  = 1'b1;
                    state_nxt_s   = ST_DONE;
                end else begin
                    state_nxt_s   = ST_R;
                end
            end
            ST_AW_W: begin
                // AW and W complete independently, in any order or together;
                // each valid drops right after its own handshake.
                aw_done_nxt_s = aw_done_r | aw_hs_s;
                w_done_nxt_s  = w_done_r | w_hs_s;
                awvalid_nxt_s = awvalid_r & ~aw_hs_s;
                wvalid_nxt_s  = wvalid_r & ~w_hs_s;
                if (aw_done_nxt_s && w_done_nxt_s) begin
                    bready_nxt_s = 1'b1;
                    state_nxt_s  = ST_B;
                end else begin
                    state_nxt_s  = ST_AW_W;
                end
            end
            ST_B: begin
                if (bready_r && axi.bvalid) begin
                    bready_nxt_s = 1'b0;
                    reload_nxt_s = 1'b1;
                    state_nxt_s  = ST_DONE;
                end else begin
                    state_nxt_s  = ST_B;
                end
            end
            ST_DONE: begin
                // Requester updates its request level during this cycle.
                state_nxt_s = ST_IDLE;
            end
            default: begin
                arvalid_nxt_s = 1'b0;
                rready_nxt_s  = 1'b0;
                awvalid_nxt_s = 1'b0;
                wvalid_nxt_s  = 1'b0;
                bready_nxt_s  = 1'b0;
                state_nxt_s   = ST_IDLE;
            end
        endcase
    end

    // State and registered-output flops with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            reload_r  <= 1'b0;
            rd_data_r <= 32'h0000_0000;
            araddr_r  <= 32'h0000_0000;
            arvalid_r <= 1'b0;
            rready_r  <= 1'b0;
            awaddr_r  <= 32'h0000_0000;
            awvalid_r <= 1'b0;
            wdata_r   <= 32'h0000_0000;
            wstrb_r   <= 4'b0000;
            wvalid_r  <= 1'b0;
            bready_r  <= 1'b0;
            aw_done_r <= 1'b0;
            w_done_r  <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            reload_r  <= reload_nxt_s;
            rd_data_r <= rd_data_nxt_s;
            araddr_r  <= araddr_nxt_s;
            arvalid_r <= arvalid_nxt_s;
            rready_r  <= rready_nxt_s;
            awaddr_r  <= awaddr_nxt_s;
            awvalid_r <= awvalid_nxt_s;
            wdata_r   <= wdata_nxt_s;
            wstrb_r   <= wstrb_nxt_s;
            wvalid_r  <= wvalid_nxt_s;
            bready_r  <= bready_nxt_s;
            aw_done_r <= aw_done_nxt_s;
            w_done_r  <= w_done_nxt_s;
        end
    end

endmodule
